// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: pin synchronisers, clock deglitch filter, frame deserialiser
// and a small frame FIFO. Build with PS2_RX_TIMEOUT_EN to abort stalled partial frames.
module ps2_rx_fifo #(
  parameter int DATA_BITS      = 8,
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 CLK,
  input  logic                 Resetn,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 busy,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overflow,
  input  logic                 err_clr
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          clk_filt, fe;
  logic [FW-1:0] flt_cnt;

  state_t               state, state_nx;
  logic [BW-1:0]        bit_cnt, bit_cnt_nx;
  logic                 par_acc, par_acc_nx;
  logic                 par_ok, par_ok_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic                 push, set_perr, set_ferr, timeout;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 full, pop, do_push, set_ovf;

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // flt_cnt counts consecutive samples that disagree with the accepted level
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      fe       <= 1'b0;
    end else begin
      fe <= 1'b0;
      if (clk_s2 != clk_filt) begin
        if (flt_cnt == FLT_LAST) begin
          clk_filt <= clk_s2;
          flt_cnt  <= '0;
          fe       <= clk_filt;
        end else begin
          flt_cnt <= flt_cnt + FW'(1);
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt;

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      to_cnt <= '0;
    end else if (state == S_IDLE || fe || timeout) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + TW'(1);
    end
  end

  assign timeout = (state != S_IDLE) && !fe && (to_cnt == TO_LAST);
`else
  // A stalled frame waits forever; TIMEOUT_CYCLES has no effect in this build.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      state   <= S_IDLE;
      bit_cnt <= '0;
      par_acc <= 1'b0;
      par_ok  <= 1'b0;
      shreg   <= '0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      par_acc <= par_acc_nx;
      par_ok  <= par_ok_nx;
      shreg   <= shreg_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    par_acc_nx = par_acc;
    par_ok_nx  = par_ok;
    shreg_nx   = shreg;
    push       = 1'b0;
    set_perr   = 1'b0;
    set_ferr   = 1'b0;
    if (timeout) begin
      state_nx = S_IDLE;
      set_ferr = 1'b1;
    end else if (fe) begin
      case (state)
        S_IDLE: begin
          if (!dat_s2) begin
            state_nx   = S_DATA;
            bit_cnt_nx = '0;
            par_acc_nx = 1'b0;
          end
        end
        S_DATA: begin
          shreg_nx   = {dat_s2, shreg[DATA_BITS-1:1]};
          par_acc_nx = par_acc ^ dat_s2;
          bit_cnt_nx = bit_cnt + BW'(1);
          if (bit_cnt == BIT_LAST) state_nx = S_PARITY;
        end
        S_PARITY: begin
          par_ok_nx = par_acc ^ dat_s2;
          state_nx  = S_STOP;
        end
        S_STOP: begin
          if (dat_s2) begin
            if (par_ok) push = 1'b1;
            else        set_perr = 1'b1;
          end else begin
            set_ferr = 1'b1;
            set_perr = !par_ok;
          end
          state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign rd_valid = (count != '0);
  assign pop      = rd_valid & rd_ready;
  assign do_push  = push & (!full | pop);
  assign set_ovf  = push & full & !pop;
  assign rd_data  = mem[rd_ptr];

  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= shreg;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // a set event in the same cycle as err_clr keeps the flag set
  always_ff @(posedge CLK or negedge Resetn) begin
    if (!Resetn) begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      parity_err <= set_perr | (parity_err & ~err_clr);
      frame_err  <= set_ferr | (frame_err & ~err_clr);
      overflow   <= set_ovf | (overflow & ~err_clr);
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: frame vector table plus hand sequences for latency,
// overflow, glitch rejection, mid-frame reset and (with PS2_RX_TIMEOUT_EN) the stall timeout.
module tb_ps2_rx_fifo;

  localparam int HALF = 50;
`ifdef PS2_RX_TIMEOUT_EN
  localparam int FIRST_HALF = 50;
`else
  localparam int FIRST_HALF = 500;
`endif

  logic       CLK = 1'b0;
  logic       Resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready = 1'b0;
  logic       busy, parity_err, frame_err, overflow;
  logic       err_clr = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_rx_fifo #(
    .DATA_BITS(8), .FILTER_LEN(4), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(200)
  ) dut (
    .CLK(CLK), .Resetn(Resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready), .busy(busy),
    .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow),
    .err_clr(err_clr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic       pflip;
    logic       stop;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
    logic       eo;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] d, input logic pflip,
                                             input logic stop);
    logic par;
    par = ~(^d) ^ pflip;
    return {stop, par, d, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits, input int half);
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLK);
      ps2_data = f[i];
      repeat (half) @(negedge CLK);
      ps2_clk = 1'b0;
      repeat (half) @(negedge CLK);
      ps2_clk = 1'b1;
    end
    @(negedge CLK);
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pflip, input logic stop);
    send_bits(make_frame(d, pflip, stop), 11, HALF);
    repeat (20) @(negedge CLK);
  endtask

  task automatic pop_chk(input string name, input logic [7:0] exp);
    @(negedge CLK);
    chk({name, "_valid"}, 32'(rd_valid), 32'd1);
    chk({name, "_data"}, 32'(rd_data), 32'(exp));
    rd_ready = 1'b1;
    @(negedge CLK);
    rd_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge CLK);
    err_clr = 1'b1;
    @(negedge CLK);
    err_clr = 1'b0;
  endtask

  task automatic chk_flags(input string name, input logic p, input logic f, input logic o);
    chk({name, "_perr"}, 32'(parity_err), 32'(p));
    chk({name, "_ferr"}, 32'(frame_err), 32'(f));
    chk({name, "_ovf"}, 32'(overflow), 32'(o));
  endtask

  initial begin
    vecs[0] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'hAA, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[5] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};

    repeat (4) @(negedge CLK);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    Resetn = 1'b1;
    repeat (4) @(negedge CLK);

    // 0x1C with the stop-bit timing checked cycle by cycle
    send_bits(make_frame(8'h1C, 1'b0, 1'b1), 10, FIRST_HALF);
    repeat (FIRST_HALF) @(negedge CLK);
    ps2_clk = 1'b0;
    repeat (6) @(negedge CLK);
    chk("lat_busy_before", 32'(busy), 32'd1);
    chk("lat_valid_before", 32'(rd_valid), 32'd0);
    @(negedge CLK);
    chk("lat_busy_after", 32'(busy), 32'd0);
    chk("lat_valid_after", 32'(rd_valid), 32'd1);
    repeat (FIRST_HALF - 7) @(negedge CLK);
    ps2_clk = 1'b1;
    repeat (20) @(negedge CLK);
    chk_flags("first", 1'b0, 1'b0, 1'b0);
    pop_chk("first", 8'h1C);
    chk("first_empty", 32'(rd_valid), 32'd0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].clr) pulse_clr();
      send_frame(vecs[i].data, vecs[i].pflip, vecs[i].stop);
      chk($sformatf("vec%0d_valid", i), 32'(rd_valid), 32'(vecs[i].ev));
      chk_flags($sformatf("vec%0d", i), vecs[i].ep, vecs[i].ef, vecs[i].eo);
      if (vecs[i].ev) begin
        pop_chk($sformatf("vec%0d", i), vecs[i].ed);
        chk($sformatf("vec%0d_empty", i), 32'(rd_valid), 32'd0);
      end
    end

    // fill past depth: fifth frame is dropped
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b0, 1'b1);
      chk($sformatf("ovf_flag_%0d", i), 32'(overflow), 32'(i == 5));
    end
    for (int i = 1; i <= 4; i++) pop_chk($sformatf("ovf_pop%0d", i), 8'(i));
    @(negedge CLK);
    chk("ovf_empty", 32'(rd_valid), 32'd0);
    pulse_clr();
    chk_flags("ovf_clr", 1'b0, 1'b0, 1'b0);

    // short clock glitches with data low must not start a frame
    @(negedge CLK);
    ps2_data = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ps2_clk = 1'b0;
      repeat (2) @(negedge CLK);
      ps2_clk = 1'b1;
      repeat (10) @(negedge CLK);
      chk($sformatf("glitch_busy%0d", i), 32'(busy), 32'd0);
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge CLK);

    // populate FIFO and flags, start a frame, then reset mid-frame
    send_frame(8'h1C, 1'b1, 1'b1);
    send_frame(8'h12, 1'b0, 1'b1);
    send_bits(make_frame(8'h0F, 1'b0, 1'b1), 4, HALF);
    repeat (5) @(negedge CLK);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    Resetn = 1'b0;
    repeat (3) @(negedge CLK);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_data", 32'(rd_data), 32'd0);
    chk_flags("mid_rst", 1'b0, 1'b0, 1'b0);
    Resetn = 1'b1;
    repeat (5) @(negedge CLK);
    send_frame(8'h5A, 1'b0, 1'b1);
    chk_flags("post_rst", 1'b0, 1'b0, 1'b0);
    pop_chk("post_rst", 8'h5A);
    @(negedge CLK);
    chk("post_rst_empty", 32'(rd_valid), 32'd0);

`ifdef PS2_RX_TIMEOUT_EN
    // start bit plus four data bits, then the clock stops
    send_bits(make_frame(8'h33, 1'b0, 1'b1), 5, HALF);
    chk("to_busy_early", 32'(busy), 32'd1);
    repeat (100) @(negedge CLK);
    chk("to_busy_mid", 32'(busy), 32'd1);
    repeat (100) @(negedge CLK);
    chk("to_busy_late", 32'(busy), 32'd0);
    chk_flags("to", 1'b0, 1'b1, 1'b0);
    chk("to_valid", 32'(rd_valid), 32'd0);
    send_frame(8'h29, 1'b0, 1'b1);
    pop_chk("to_next", 8'h29);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
